// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits count_in pulses of HIGH_CYCLES high / LOW_CYCLES low,
// with registered pulse_out/busy/done, abort, and a one-cycle done strobe on normal completion.
module pulse_train_gen #(
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] count_in,
  output logic       pulse_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] remaining
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] HIGH_LOAD = 4'(HIGH_CYCLES - 1);
  localparam logic [3:0] LOW_LOAD  = 4'(LOW_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rem_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = remaining;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count_in != 8'd0) begin
            rem_d   = count_in;
            cnt_d   = HIGH_LOAD;
            state_d = HIGH;
          end else begin
            rem_d   = '0;
            state_d = DONE;
          end
        end
      end
      HIGH: begin
        if (abort) begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          rem_d   = (remaining != 8'd0) ? remaining - 8'd1 : '0;
          cnt_d   = LOW_LOAD;
          state_d = LOW;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LOW: begin
        if (abort) begin
          rem_d   = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          if (remaining != 8'd0) begin
            cnt_d   = HIGH_LOAD;
            state_d = HIGH;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        rem_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are flops loaded from the next-state decode, so they line up with state_q
  // while never exposing a combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      remaining <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      remaining <= rem_d;
      pulse_out <= (state_d == HIGH);
      busy      <= (state_d == HIGH) || (state_d == LOW);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: stimulus queues per-cycle expectations keyed by
// clock edge count; a negedge monitor compares DUT outputs whenever an expectation is due.
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] count_in;
  logic       pulse_out;
  logic       busy;
  logic       done;
  logic [7:0] remaining;

  pulse_train_gen #(.HIGH_CYCLES(2), .LOW_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .count_in  (count_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          key;
    logic [10:0] exp;
    logic        chk_ec;
    logic [7:0]  ec;
  } item_t;

  item_t q_exp[$];
  string q_name[$];
  int    cyc = 0;
  bit    sim_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream 8-bit saturating rising-edge counter
  logic       ec_clr = 1'b0;
  logic [7:0] ec = '0;
  logic       prev_p = 1'b0;
  always @(posedge clk) begin
    if (ec_clr) ec <= '0;
    else if (pulse_out && !prev_p && ec != 8'hFF) ec <= ec + 8'd1;
    prev_p <= pulse_out;
  end

  // expected {pulse, busy, done, remaining} at cycle t after a start sampled with count k
  function automatic logic [10:0] model(input int k, input int t);
    int ph;
    logic [7:0] r;
    if (t <= 4 * k) begin
      ph = (t - 1) % 4;
      r  = 8'(k - (t - 1) / 4 - ((ph >= 2) ? 1 : 0));
      return {(ph < 2), 1'b1, 1'b0, r};
    end else if (t == 4 * k + 1) begin
      return {3'b001, 8'h00};
    end
    return '0;
  endfunction

  task automatic push(input int key, input logic [10:0] e, input string nm);
    item_t it;
    it.key = key; it.exp = e; it.chk_ec = 1'b0; it.ec = '0;
    q_exp.push_back(it);
    q_name.push_back(nm);
  endtask

  task automatic push_train(input int base, input int k, input bit chk, input string nm);
    item_t it;
    for (int t = 1; t <= 4 * k + 2; t++) begin
      it.key = base + t; it.exp = model(k, t);
      it.chk_ec = chk && (t == 4 * k + 1);
      it.ec = (k > 255) ? 8'hFF : 8'(k);
      q_exp.push_back(it);
      q_name.push_back(nm);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_train(input int k, input bit chk, input string nm);
    push_train(cyc, k, chk, nm);
    start = 1'b1; count_in = 8'(k);
    tick();
    start = 1'b0; count_in = 8'h5A;
    repeat (4 * k + 1) tick();
  endtask

  // monitor / scoreboard
  int checks = 0;
  int errors = 0;
  int rd = 0;
  always @(negedge clk) begin
    while (rd < q_exp.size() && q_exp[rd].key < cyc) begin
      checks++; errors++;
      $display("FAIL %s: expectation for cycle %0d never compared (now %0d)", q_name[rd], q_exp[rd].key, cyc);
      rd++;
    end
    if (rd < q_exp.size() && q_exp[rd].key == cyc) begin
      checks++;
      if ({pulse_out, busy, done, remaining} !== q_exp[rd].exp) begin
        errors++;
        $display("FAIL %s cyc=%0d: got p/b/d/rem=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 q_name[rd], cyc, pulse_out, busy, done, remaining,
                 q_exp[rd].exp[10], q_exp[rd].exp[9], q_exp[rd].exp[8], q_exp[rd].exp[7:0]);
      end
      if (q_exp[rd].chk_ec) begin
        checks++;
        if (ec !== q_exp[rd].ec) begin
          errors++;
          $display("FAIL %s edge_count: got %0d want %0d", q_name[rd], ec, q_exp[rd].ec);
        end
      end
      rd++;
    end
    if (sim_done || cyc > 4000) begin
      checks++;
      if (!sim_done || rd != q_exp.size()) begin
        errors++;
        $display("FAIL drain: sim_done=%0d compared %0d of %0d expectations", sim_done, rd, q_exp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; count_in = '0;
    tick();
    push(cyc + 1, '0, "reset_state");
    push(cyc + 2, '0, "reset_state");
    tick(); tick();
    reset = 1'b1;
    tick();

    run_train(3, 1'b0, "train3");
    run_train(0, 1'b0, "count0");
    run_train(2, 1'b0, "start_after_done");

    // abort in second high cycle of pulse 2 of 5
    for (int t = 1; t <= 6; t++) push(cyc + t, model(5, t), "abort_pre");
    for (int t = 7; t <= 10; t++) push(cyc + t, '0, "abort_post");
    start = 1'b1; count_in = 8'd5;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();

    // start mid-train ignored
    push_train(cyc, 2, 1'b0, "restart_ignored");
    start = 1'b1; count_in = 8'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    start = 1'b1; count_in = 8'd9;
    tick();
    start = 1'b0; count_in = 8'd0;
    repeat (6) tick();

    // abort and start together in IDLE
    for (int t = 1; t <= 4; t++) push(cyc + t, '0, "abort_wins_idle");
    start = 1'b1; abort = 1'b1; count_in = 8'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();

    // abort during DONE
    push_train(cyc, 0, 1'b0, "abort_in_done");
    start = 1'b1; count_in = 8'd0;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // reset glitch between edges during HIGH is invisible
    push_train(cyc, 2, 1'b0, "reset_glitch");
    start = 1'b1; count_in = 8'd2;
    tick();
    start = 1'b0;
    #1 reset = 1'b0;
    #2 reset = 1'b1;
    repeat (9) tick();

    // synchronous reset mid-HIGH
    push(cyc + 1, model(3, 1), "reset_midhigh_pre");
    push(cyc + 2, '0, "reset_midhigh");
    push(cyc + 3, '0, "reset_midhigh_post");
    start = 1'b1; count_in = 8'd3;
    tick();
    start = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // full 255-pulse train into the edge counter
    ec_clr = 1'b1;
    tick();
    ec_clr = 1'b0;
    run_train(255, 1'b1, "count255");

    repeat (3) tick();
    sim_done = 1'b1;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter HIGH_CYCLES, default 2: pulse_out high time per pulse, in clk cycles; legal range 1..15.
REQ-002 Parameter LOW_CYCLES, default 2: pulse_out low time after each pulse, in clk cycles; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous and active-low; sampled on rising clk edge only.
REQ-005 start  input  1  request to emit a pulse train; sampled only in IDLE.
REQ-006 abort  input  1  terminate the current train immediately.
REQ-007 count_in  input  8  number of pulses to emit (0..255); captured with start.
REQ-008 pulse_out  output  1  generated pulse train, registered, glitch-free.
REQ-009 busy  output  1  high while a train is in progress.
REQ-010 done  output  1  one-cycle strobe on normal completion.
REQ-011 remaining  output  8  pulses not yet completed in the current train.

Function
REQ-012 The FSM SHALL have states IDLE, HIGH, LOW and DONE, with a duration counter of at least 4 bits.
REQ-013 IDLE with start=1, abort=0, count_in!=0: latch count_in into remaining, load the duration counter, enter HIGH.
REQ-014 IDLE with start=1, abort=0, count_in=0: enter DONE directly; pulse_out stays 0.
REQ-015 HIGH: pulse_out=1 for exactly HIGH_CYCLES cycles, then remaining decrements by 1 and the FSM enters LOW.
REQ-016 LOW: pulse_out=0 for exactly LOW_CYCLES cycles; then HIGH if remaining!=0, else DONE.
REQ-017 DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
REQ-018 Latency: start sampled at edge N drives pulse_out=1 in cycle N+1.
REQ-019 A train of K pulses SHALL occupy busy=1 for exactly K*(HIGH_CYCLES+LOW_CYCLES) cycles.
REQ-020 done SHALL follow the last busy cycle directly.
REQ-021 busy=1 in HIGH and LOW; busy=0 in IDLE and DONE.
REQ-022 pulse_out, busy and done SHALL be driven from registers, with no combinational path from inputs.
REQ-023 start outside IDLE SHALL be ignored, and count_in SHALL NOT be re-sampled mid-train.
REQ-024 abort=1 in HIGH or LOW: next cycle IDLE, pulse_out=0, busy=0, remaining=0, no done strobe; a truncated high phase is accepted.
REQ-025 abort and start both 1 in IDLE: abort wins and no train starts.
REQ-026 abort in DONE: done still completes its single cycle.
REQ-027 remaining SHALL never wrap below 0.
REQ-028 count_in=255 SHALL produce exactly 255 pulses, with no 8-bit overflow in any counter.
REQ-029 Consecutive pulses SHALL be separated by at least one low cycle, so each pulse presents exactly one rising edge to a downstream edge counter.
REQ-030 A start in the cycle after done SHALL be accepted, because the FSM is already in IDLE.

Reset
REQ-031 reset=0 at a rising clk edge forces IDLE, pulse_out=0, busy=0, done=0, remaining=0 and duration counter=0.
REQ-032 Reset SHALL take effect from any state, including mid-pulse, and SHALL take priority over start and abort.
REQ-033 Reset SHALL have no asynchronous effect: between clk edges, outputs hold their values regardless of reset.

Verification
REQ-034 Defaults, start with count_in=3 at edge N -> pulse_out high in N+1..N+2, N+5..N+6, N+9..N+10; busy N+1..N+12; done at N+13; remaining steps 3,2,1,0.
REQ-035 start with count_in=0 -> done=1 in the next cycle; pulse_out and busy stay 0.
REQ-036 count_in=255, with pulse_out fed to an 8-bit saturating rising-edge counter -> counter reads 255 after done; exactly 255 rising edges.
REQ-037 abort in the second high cycle of pulse 2 of 5 -> pulse_out=0 and busy=0 next cycle; remaining=0; done never asserts.
REQ-038 start pulsed again mid-train with count_in=9 -> ignored; the original train length is unchanged.
REQ-039 Synchronous reset asserted mid-HIGH -> all outputs 0 after that edge; a glitch on reset between clk edges has no effect.
